// File: rtl/t03_pkg.sv
// ---------------------------------------------------------------------------
// t03_pkg
// Shared definitions for the instruction-fetch responder and its helpers:
//   - fetch_state_e      : fetch FSM encoding (IDLE, REQ, WAIT, VALID)
//   - T03_NOP_INSTR      : word presented after reset or an aborted fetch
//   - T03_TIMEOUT_CYCLES : default cycle budget for a bus acknowledge
//   - T03_CNT_W          : default width of the timeout counter
//   - fetch_stalls()     : whether the PC must be held in a given state
// ---------------------------------------------------------------------------
package t03_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_REQ   = 2'd1,
        FS_WAIT  = 2'd2,
        FS_VALID = 2'd3
    } fetch_state_e;

    // RV32I addi x0,x0,0
    localparam logic [31:0] T03_NOP_INSTR      = 32'h0000_0013;
    localparam int unsigned T03_TIMEOUT_CYCLES = 32'd255;
    localparam int unsigned T03_CNT_W          = 32'd8;

    // The PC may advance only in the single VALID cycle of a fetch.
    function automatic logic fetch_stalls(input fetch_state_e st);
        return (st != FS_VALID);
    endfunction

endpackage : t03_pkg

// File: rtl/t03_fetch_timer.sv
// ---------------------------------------------------------------------------
// t03_fetch_timer
// Saturating cycle counter with synchronous clear and count enable.
// term_o is high when the count has reached LIMIT, or when the current
// enabled cycle is the one that brings it there, so a caller can act in the
// same cycle the budget runs out.
// Ports:
//   clk    in   clock
//   nrst   in   asynchronous active-low reset (count -> 0)
//   clr_i  in   clear count to zero (wins over en_i)
//   en_i   in   count one cycle
//   term_o out  budget of LIMIT enabled cycles exhausted
// ---------------------------------------------------------------------------
module t03_fetch_timer #(
    parameter int unsigned CNT_W = 32'd8,
    parameter int unsigned LIMIT = 32'd255
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam logic [CNT_W-1:0] LIMIT_C    = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1_C = CNT_W'(LIMIT - 32'd1);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] ZERO_C     = CNT_W'(32'd0);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = ZERO_C;
        end else if (en_i && (count_q != LIMIT_C)) begin
            count_d = count_q + ONE_C;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_q <= ZERO_C;
        end else begin
            count_q <= count_d;
        end
    end

    assign term_o = (count_q == LIMIT_C) |
                    (en_i & ~clr_i & (count_q == LIMIT_M1_C));

endmodule : t03_fetch_timer

// File: rtl/t03_instr_fetch.sv
// ---------------------------------------------------------------------------
// t03_instr_fetch
// Memory-side responder for the PC fetch stream. Latches the fetch address,
// issues one read on the shared bus, holds the returned word for the decoder
// and stalls the PC (freeze_pc) except for the one cycle after a fetch ends.
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   fetch_addr/fetch_en  next fetch address / core ready for a new word
//   flush                drop the result of the current fetch
//   bus_busy             bus granted to data side, hold the request off
//   bus_ack/bus_rdata    one-cycle read acknowledge and its data
//   bus_req/bus_addr     registered read request and address
//   instr/instr_valid    word to decoder and its validity
//   freeze_pc            PC stall
//   fetch_err            one-cycle pulse when a fetch times out
// ---------------------------------------------------------------------------
module t03_instr_fetch
    import t03_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = T03_TIMEOUT_CYCLES,
    parameter logic [31:0] NOP_INSTR      = T03_NOP_INSTR,
    parameter int unsigned CNT_W          = T03_CNT_W
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_en,
    input  logic        flush,
    input  logic        bus_busy,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        freeze_pc,
    output logic        fetch_err
);

    fetch_state_e state_q, state_d;
    logic         bus_req_q, bus_req_d;
    logic [31:0]  bus_addr_q, bus_addr_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         fetch_err_q, fetch_err_d;
    logic         freeze_q, freeze_d;
    logic         flushed_q, flushed_d;   // flush seen earlier in this WAIT
    logic         capture_s;              // a word becomes valid this cycle
    logic         drop_s;                 // current result must be discarded
    logic         timer_term_s;

    assign drop_s = flush | flushed_q;

    // Counter is held clear while requesting and runs only while waiting.
    t03_fetch_timer #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .nrst   (nrst),
        .clr_i  (state_q == FS_REQ),
        .en_i   (state_q == FS_WAIT),
        .term_o (timer_term_s)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= FS_IDLE;
            bus_req_q     <= 1'b0;
            bus_addr_q    <= 32'h0000_0000;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            freeze_q      <= 1'b1;
            flushed_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_addr_q    <= bus_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
            freeze_q      <= freeze_d;
            flushed_q     <= flushed_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_IDLE: begin
                if (fetch_en) state_d = FS_REQ;
                else          state_d = FS_IDLE;
            end
            FS_REQ: begin
                if (!bus_busy) state_d = FS_WAIT;
                else           state_d = FS_REQ;
            end
            FS_WAIT: begin
                if (bus_ack || timer_term_s) state_d = FS_VALID;
                else                         state_d = FS_WAIT;
            end
            FS_VALID: begin
                if (fetch_en) state_d = FS_REQ;
                else          state_d = FS_IDLE;
            end
            default: state_d = FS_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        bus_req_d  = bus_req_q;
        bus_addr_d = bus_addr_q;
        instr_d    = instr_q;
        fetch_err_d = 1'b0;
        flushed_d  = 1'b0;
        capture_s  = 1'b0;
        case (state_q)
            FS_IDLE, FS_VALID: begin
                bus_req_d = 1'b0;
                if (fetch_en) bus_addr_d = fetch_addr;
                else          bus_addr_d = bus_addr_q;
            end
            FS_REQ: begin
                // Request goes out only once the data side releases the bus.
                if (!bus_busy) bus_req_d = 1'b1;
                else           bus_req_d = 1'b0;
            end
            FS_WAIT: begin
                // An acknowledge on the last budget cycle still counts.
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!drop_s) begin
                        instr_d   = bus_rdata;
                        capture_s = 1'b1;
                    end else begin
                        instr_d   = instr_q;
                    end
                end else if (timer_term_s) begin
                    bus_req_d   = 1'b0;
                    fetch_err_d = 1'b1;
                    if (!drop_s) begin
                        instr_d   = NOP_INSTR;
                        capture_s = 1'b1;
                    end else begin
                        instr_d   = instr_q;
                    end
                end else begin
                    bus_req_d = 1'b1;
                    flushed_d = drop_s;
                end
            end
            default: begin
                bus_req_d = 1'b0;
            end
        endcase
        instr_valid_d = flush ? 1'b0 : (capture_s ? 1'b1 : instr_valid_q);
        freeze_d      = fetch_stalls(state_d);
    end

    assign bus_req     = bus_req_q;
    assign bus_addr    = bus_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign freeze_pc   = freeze_q;
    assign fetch_err   = fetch_err_q;

endmodule : t03_instr_fetch

// File: tb/tb_t03_instr_fetch.sv
module tb_t03_instr_fetch;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] fetch_addr;
    logic        fetch_en;
    logic        flush;
    logic        bus_busy;
    logic        resp_ack;
    logic        stray_ack;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        freeze_pc;
    logic        fetch_err;

    typedef struct {
        int          cyc;
        logic [31:0] instr;
        logic        vld;
        logic        err;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb_q[$];
    int          total;
    int          bad;
    int          cyc;
    int          ack_lat;     // WAIT cycles before ack; negative = never
    logic [31:0] rdata_next;

    localparam logic [31:0] NOP = 32'h0000_0013;

    assign bus_ack = resp_ack | stray_ack;

    t03_instr_fetch #(
        .TIMEOUT_CYCLES (32'd8)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .fetch_addr  (fetch_addr),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .bus_busy    (bus_busy),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .freeze_pc   (freeze_pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_valid(input int at, input logic [31:0] ins, input logic v,
                                input logic e, input logic [31:0] a);
        exp_t x;
        x.cyc = at; x.instr = ins; x.vld = v; x.err = e; x.addr = a;
        sb_q.push_back(x);
    endtask

    // Memory model: acknowledges ack_lat cycles into an active request.
    initial begin
        int wcnt;
        wcnt = 0;
        resp_ack = 1'b0;
        bus_rdata = 32'h0000_0000;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req === 1'b1) begin
                if (ack_lat >= 0 && wcnt == ack_lat) begin
                    resp_ack  = 1'b1;
                    bus_rdata = rdata_next;
                end else begin
                    resp_ack  = 1'b0;
                    bus_rdata = 32'hBAD0_0000;
                end
                wcnt++;
            end else begin
                resp_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: each PC-advance cycle is one completed fetch.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (nrst === 1'b1) begin
                if (freeze_pc === 1'b0) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_valid cyc=%0d actual=freeze_low required=none", cyc);
                    end else begin
                        e = sb_q.pop_front();
                        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                        chk("valid_instr", instr, e.instr);
                        chk("valid_instr_valid", {31'd0, instr_valid}, {31'd0, e.vld});
                        chk("valid_fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
                        chk("valid_bus_addr", bus_addr, e.addr);
                    end
                end else begin
                    chk("err_outside_valid", {31'd0, fetch_err}, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        addrs = '{32'h10, 32'h14, 32'h18};
        datas = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
        total = 0; bad = 0; cyc = 0;
        nrst = 1'b0; fetch_en = 1'b0; fetch_addr = 32'h0; flush = 1'b0;
        bus_busy = 1'b0; stray_ack = 1'b0; ack_lat = 0; rdata_next = 32'h0;

        // Reset state
        #12;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_freeze", {31'd0, freeze_pc}, 32'd1);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        tick();
        nrst = 1'b1;
        tick();

        // T1: basic fetch, ack in first WAIT cycle
        c = cyc;
        fetch_en = 1'b1; fetch_addr = 32'h0; ack_lat = 0; rdata_next = 32'h0050_0093;
        expect_valid(c + 3, 32'h0050_0093, 1'b1, 1'b0, 32'h0);
        tick(); fetch_en = 1'b0;
        chk("t1_req_low_in_req", {31'd0, bus_req}, 32'd0);
        tick();
        chk("t1_req_high_in_wait", {31'd0, bus_req}, 32'd1);
        tick();
        chk("t1_req_low_in_valid", {31'd0, bus_req}, 32'd0);
        tick();
        chk("t1_freeze_back_high", {31'd0, freeze_pc}, 32'd1);

        // T2: bus busy holds the request off
        c = cyc;
        fetch_en = 1'b1; fetch_addr = 32'h4; bus_busy = 1'b1; rdata_next = 32'h0040_0113;
        expect_valid(c + 7, 32'h0040_0113, 1'b1, 1'b0, 32'h4);
        for (int i = 0; i < 5; i++) begin
            tick(); fetch_en = 1'b0;
            chk("t2_req_while_busy", {31'd0, bus_req}, 32'd0);
            chk("t2_addr_while_busy", bus_addr, 32'h4);
            chk("t2_freeze_while_busy", {31'd0, freeze_pc}, 32'd1);
        end
        bus_busy = 1'b0;
        tick();
        chk("t2_req_after_busy", {31'd0, bus_req}, 32'd1);
        chk("t2_addr_after_busy", bus_addr, 32'h4);
        tick(); tick();

        // T3: no ack, timeout after 8 WAIT cycles
        c = cyc;
        fetch_en = 1'b1; fetch_addr = 32'h8; ack_lat = -1;
        expect_valid(c + 10, NOP, 1'b1, 1'b1, 32'h8);
        tick(); fetch_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_req_held", {31'd0, bus_req}, 32'd1);
        end
        tick();
        chk("t3_req_dropped", {31'd0, bus_req}, 32'd0);
        tick();
        chk("t3_err_single_pulse", {31'd0, fetch_err}, 32'd0);

        // T4: flush during WAIT, late ack data discarded
        c = cyc;
        fetch_en = 1'b1; fetch_addr = 32'hC; ack_lat = 2; rdata_next = 32'hDEAD_BEEF;
        expect_valid(c + 5, NOP, 1'b0, 1'b0, 32'hC);
        tick(); fetch_en = 1'b0;
        tick(); flush = 1'b1;
        tick(); flush = 1'b0;
        chk("t4_valid_cleared", {31'd0, instr_valid}, 32'd0);
        chk("t4_req_still_held", {31'd0, bus_req}, 32'd1);
        tick(); tick(); tick();

        // T5: back-to-back fetches
        ack_lat = 0;
        for (int k = 0; k < 3; k++) begin
            c = cyc;
            fetch_en = 1'b1; fetch_addr = addrs[k]; rdata_next = datas[k];
            expect_valid(c + 3, datas[k], 1'b1, 1'b0, addrs[k]);
            tick();
            chk("t5_addr_req", bus_addr, addrs[k]);
            tick();
            chk("t5_addr_wait", bus_addr, addrs[k]);
            tick();
        end
        fetch_en = 1'b0;
        tick();

        // Stray ack in IDLE is ignored
        stray_ack = 1'b1;
        tick(); stray_ack = 1'b0;
        tick();
        chk("stray_ack_instr", instr, datas[2]);
        chk("stray_ack_valid", {31'd0, instr_valid}, 32'd1);
        chk("stray_ack_req", {31'd0, bus_req}, 32'd0);
        chk("stray_ack_freeze", {31'd0, freeze_pc}, 32'd1);

        // T6: asynchronous reset in the middle of WAIT
        fetch_en = 1'b1; fetch_addr = 32'h20; ack_lat = -1;
        tick(); fetch_en = 1'b0;
        tick(); tick();
        chk("t6_req_before_reset", {31'd0, bus_req}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        chk("t6_async_bus_req", {31'd0, bus_req}, 32'd0);
        chk("t6_async_freeze", {31'd0, freeze_pc}, 32'd1);
        chk("t6_async_instr", instr, NOP);
        chk("t6_async_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_async_addr", bus_addr, 32'd0);
        tick();
        nrst = 1'b1;
        tick();

        // Recovery fetch after reset
        c = cyc;
        fetch_en = 1'b1; fetch_addr = 32'h24; ack_lat = 0; rdata_next = 32'h0000_0073;
        expect_valid(c + 3, 32'h0000_0073, 1'b1, 1'b0, 32'h24);
        tick(); fetch_en = 1'b0;
        repeat (5) tick();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_t03_instr_fetch
